// File: rtl/img_read_seq.sv
// Frame read sequencer: walks a CHANNELS x ROWS x COLS buffer, issues one read per
// cycle and delivers coordinate tags aligned to the fixed-latency read data.
module img_read_seq #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned MODE     = 0,
  localparam int unsigned N  = ROWS * COLS * CHANNELS,
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          valid_out,
  output logic [RW-1:0] row_addr,
  output logic [CW-1:0] col_addr,
  output logic [HW-1:0] cha_addr,
  output logic          last_out,
  output logic          done
);

  localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned TW = 2 + RW + CW + HW;
  localparam int unsigned PW = RD_LAT * TW;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic          issue;
  logic [DW-1:0] drain_cnt;
  logic [AW-1:0] addr;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [HW-1:0] cha, cha_nxt;
  logic          addr_last, row_last, col_last, cha_last;
  logic [TW-1:0] tag_in;
  logic [PW-1:0] pipe;

  assign addr_last = (addr == AW'(N - 1));
  assign row_last  = (row == RW'(ROWS - 1));
  assign col_last  = (col == CW'(COLS - 1));
  assign cha_last  = (cha == HW'(CHANNELS - 1));

  // Next state and read issue
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ: begin
        issue = !pause;
        if (issue && addr_last) state_nxt = DRAIN;
      end
      DRAIN:   if (drain_cnt == DW'(RD_LAT - 1)) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinate advance in scan order; the final element wraps everything back to 0
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    cha_nxt = cha;
    if (MODE == 0) begin
      col_nxt = col_last ? '0 : col + CW'(1);
      if (col_last) row_nxt = row_last ? '0 : row + RW'(1);
      if (col_last && row_last) cha_nxt = cha_last ? '0 : cha + HW'(1);
    end else begin
      cha_nxt = cha_last ? '0 : cha + HW'(1);
      if (cha_last) col_nxt = col_last ? '0 : col + CW'(1);
      if (cha_last && col_last) row_nxt = row_last ? '0 : row + RW'(1);
    end
  end

  assign tag_in = issue ? {1'b1, addr_last, row, col, cha} : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
      addr      <= '0;
      row       <= '0;
      col       <= '0;
      cha       <= '0;
      pipe      <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      if (issue) begin
        addr <= addr_last ? '0 : addr + AW'(1);
        row  <= row_nxt;
        col  <= col_nxt;
        cha  <= cha_nxt;
      end
      // Tag shift register never stalls; unissued cycles enter as zero bubbles
      pipe <= PW'({pipe, tag_in});
    end
  end

  assign rd_en   = issue;
  assign rd_addr = addr;
  assign {valid_out, last_out, row_addr, col_addr, cha_addr} = pipe[PW-1 -: TW];

endmodule

// File: tb/tb_img_read_seq.sv
// Bench for img_read_seq: four configurations checked every cycle against an
// index-based frame model, plus literal expectations for key events.
module tb_img_read_seq;

  localparam int unsigned R_0 = 8, C_0 = 8, H_0 = 3, L_0 = 2, M_0 = 0;
  localparam int unsigned R_1 = 5, C_1 = 3, H_1 = 2, L_1 = 2, M_1 = 1;
  localparam int unsigned R_2 = 3, C_2 = 4, H_2 = 2, L_2 = 1, M_2 = 0;
  localparam int unsigned R_3 = 2, C_3 = 3, H_3 = 3, L_3 = 4, M_3 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start, pause;
  logic [3:0] busy_v, rd_en_v, valid_v, last_v, done_v;
  logic [31:0] addr_v [4];
  logic [31:0] row_v  [4];
  logic [31:0] col_v  [4];
  logic [31:0] cha_v  [4];

  logic [7:0] a0; logic [2:0] r0; logic [2:0] c0w; logic [1:0] h0;
  logic [4:0] a1; logic [2:0] r1; logic [1:0] c1w; logic [0:0] h1;
  logic [4:0] a2; logic [1:0] r2; logic [1:0] c2w; logic [0:0] h2;
  logic [4:0] a3; logic [0:0] r3; logic [1:0] c3w; logic [1:0] h3;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  int cf_rows [4], cf_cols [4], cf_ch [4], cf_lat [4], cf_mode [4];

  // Model state and event recorder
  int   phase [4], n_iss [4], dcnt [4];
  int   hist [4][4];
  int   rec_n [4], first_en [4], done_rise [4], done_fall [4];
  int   rec_r [4][192], rec_c [4][192], rec_h [4][192], rec_l [4][192], rec_t [4][192];
  logic [3:0] prev_done;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  img_read_seq #(.ROWS(R_0), .COLS(C_0), .CHANNELS(H_0), .RD_LAT(L_0), .MODE(M_0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .pause(pause[0]), .busy(busy_v[0]),
    .rd_en(rd_en_v[0]), .rd_addr(a0), .valid_out(valid_v[0]), .row_addr(r0),
    .col_addr(c0w), .cha_addr(h0), .last_out(last_v[0]), .done(done_v[0]));
  img_read_seq #(.ROWS(R_1), .COLS(C_1), .CHANNELS(H_1), .RD_LAT(L_1), .MODE(M_1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .pause(pause[1]), .busy(busy_v[1]),
    .rd_en(rd_en_v[1]), .rd_addr(a1), .valid_out(valid_v[1]), .row_addr(r1),
    .col_addr(c1w), .cha_addr(h1), .last_out(last_v[1]), .done(done_v[1]));
  img_read_seq #(.ROWS(R_2), .COLS(C_2), .CHANNELS(H_2), .RD_LAT(L_2), .MODE(M_2)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .pause(pause[2]), .busy(busy_v[2]),
    .rd_en(rd_en_v[2]), .rd_addr(a2), .valid_out(valid_v[2]), .row_addr(r2),
    .col_addr(c2w), .cha_addr(h2), .last_out(last_v[2]), .done(done_v[2]));
  img_read_seq #(.ROWS(R_3), .COLS(C_3), .CHANNELS(H_3), .RD_LAT(L_3), .MODE(M_3)) dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .pause(pause[3]), .busy(busy_v[3]),
    .rd_en(rd_en_v[3]), .rd_addr(a3), .valid_out(valid_v[3]), .row_addr(r3),
    .col_addr(c3w), .cha_addr(h3), .last_out(last_v[3]), .done(done_v[3]));

  assign addr_v[0] = 32'(a0); assign row_v[0] = 32'(r0); assign col_v[0] = 32'(c0w); assign cha_v[0] = 32'(h0);
  assign addr_v[1] = 32'(a1); assign row_v[1] = 32'(r1); assign col_v[1] = 32'(c1w); assign cha_v[1] = 32'(h1);
  assign addr_v[2] = 32'(a2); assign row_v[2] = 32'(r2); assign col_v[2] = 32'(c2w); assign cha_v[2] = 32'(h2);
  assign addr_v[3] = 32'(a3); assign row_v[3] = 32'(r3); assign col_v[3] = 32'(c3w); assign cha_v[3] = 32'(h3);

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  // Element index -> coordinates from the scan-order definition
  function automatic void coords(input int d, input int idx, output int r, output int c, output int h);
    if (cf_mode[d] == 0) begin
      h = idx / (cf_rows[d] * cf_cols[d]);
      r = (idx / cf_cols[d]) % cf_rows[d];
      c = idx % cf_cols[d];
    end else begin
      r = idx / (cf_cols[d] * cf_ch[d]);
      c = (idx / cf_ch[d]) % cf_cols[d];
      h = idx % cf_ch[d];
    end
  endfunction

  // Per-cycle compare against the model, then advance the model on current inputs
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      int rr, cc, hh, idx, lat, nn;
      logic e_en;
      lat = cf_lat[d];
      nn  = cf_rows[d] * cf_cols[d] * cf_ch[d];
      if (!reset) begin
        phase[d] = 0; n_iss[d] = 0; dcnt[d] = 0;
        for (int i = 0; i < 4; i++) hist[d][i] = -1;
        rec_n[d] = 0; first_en[d] = -1; done_rise[d] = -1; done_fall[d] = -1;
        chk("rst_busy", d, int'(busy_v[d]), 0);
        chk("rst_rd_en", d, int'(rd_en_v[d]), 0);
        chk("rst_rd_addr", d, int'(addr_v[d]), 0);
        chk("rst_valid", d, int'(valid_v[d]), 0);
        chk("rst_tags", d, int'(row_v[d] | col_v[d] | cha_v[d]), 0);
        chk("rst_last", d, int'(last_v[d]), 0);
        chk("rst_done", d, int'(done_v[d]), 0);
        prev_done[d] = 1'b0;
      end else begin
        idx = hist[d][lat-1];
        if (idx >= 0) coords(d, idx, rr, cc, hh);
        else begin rr = 0; cc = 0; hh = 0; end
        e_en = (phase[d] == 1) && !pause[d];
        chk("busy", d, int'(busy_v[d]), int'(phase[d] != 0));
        chk("done", d, int'(done_v[d]), int'(phase[d] == 3));
        chk("rd_en", d, int'(rd_en_v[d]), int'(e_en));
        if (e_en) chk("rd_addr", d, int'(addr_v[d]), n_iss[d]);
        chk("valid_out", d, int'(valid_v[d]), int'(idx >= 0));
        chk("row_addr", d, int'(row_v[d]), rr);
        chk("col_addr", d, int'(col_v[d]), cc);
        chk("cha_addr", d, int'(cha_v[d]), hh);
        chk("last_out", d, int'(last_v[d]), int'(idx == nn - 1));
        if (valid_v[d] && rec_n[d] < 192) begin
          rec_r[d][rec_n[d]] = int'(row_v[d]);
          rec_c[d][rec_n[d]] = int'(col_v[d]);
          rec_h[d][rec_n[d]] = int'(cha_v[d]);
          rec_l[d][rec_n[d]] = int'(last_v[d]);
          rec_t[d][rec_n[d]] = cyc;
          rec_n[d]++;
        end
        if (rd_en_v[d] && first_en[d] < 0) first_en[d] = cyc;
        if (done_v[d] && !prev_done[d]) done_rise[d] = cyc;
        if (!done_v[d] && prev_done[d]) done_fall[d] = cyc;
        prev_done[d] = done_v[d];
        for (int i = lat - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = e_en ? n_iss[d] : -1;
        case (phase[d])
          0: if (start[d]) phase[d] = 1;
          1: if (e_en) begin
               n_iss[d]++;
               if (n_iss[d] == nn) begin phase[d] = 2; dcnt[d] = 0; n_iss[d] = 0; end
             end
          2: begin dcnt[d]++; if (dcnt[d] == lat) phase[d] = 3; end
          default: if (!start[d]) phase[d] = 0;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    rec_n[d] = 0; first_en[d] = -1; done_rise[d] = -1; done_fall[d] = -1;
  endtask

  task automatic wait_done(input int d, input int budget);
    int k;
    k = 0;
    while (done_rise[d] < 0 && k < budget) begin tick(1); k++; end
    chk("done_seen", d, int'(done_rise[d] >= 0), 1);
  endtask

  task automatic chk_el(input string nm, input int d, input int e, input int r, input int c, input int h, input int l);
    chk({nm, "_row"}, d, rec_r[d][e], r);
    chk({nm, "_col"}, d, rec_c[d][e], c);
    chk({nm, "_cha"}, d, rec_h[d][e], h);
    chk({nm, "_last"}, d, rec_l[d][e], l);
  endtask

  initial begin
    int t0, k;
    cf_rows = '{R_0, R_1, R_2, R_3};
    cf_cols = '{C_0, C_1, C_2, C_3};
    cf_ch   = '{H_0, H_1, H_2, H_3};
    cf_lat  = '{L_0, L_1, L_2, L_3};
    cf_mode = '{M_0, M_1, M_2, M_3};
    reset = 1'b0; start = '0; pause = '0;
    tick(3);
    reset = 1'b1;
    tick(2);

    // Default geometry, start held through DONE
    clr(0); start[0] = 1'b1; t0 = cyc;
    wait_done(0, 400);
    chk("done_latency", 0, done_rise[0] - t0, 195);
    chk("first_issue", 0, first_en[0] - t0, 1);
    chk("n_valid", 0, rec_n[0], 192);
    chk("lag", 0, rec_t[0][0] - first_en[0], 2);
    chk_el("el0", 0, 0, 0, 0, 0, 0);
    chk_el("el64", 0, 64, 0, 0, 1, 0);
    chk_el("el190", 0, 190, 7, 6, 2, 0);
    chk_el("el191", 0, 191, 7, 7, 2, 1);
    tick(5);
    chk("done_hold", 0, int'(done_v[0]), 1);
    chk("no_rerun", 0, int'(busy_v[0] && !rd_en_v[0]), 1);
    start[0] = 1'b0; t0 = cyc;
    tick(3);
    chk("done_fall", 0, done_fall[0] - t0, 1);
    chk("busy_after", 0, int'(busy_v[0]), 0);

    // Pause during READ cycles 3..6
    clr(0); start[0] = 1'b1; t0 = cyc;
    tick(3); pause[0] = 1'b1;
    tick(4); pause[0] = 1'b0;
    wait_done(0, 400);
    chk("pause_done", 0, done_rise[0] - t0, 199);
    chk("pause_gap", 0, rec_t[0][2] - rec_t[0][1], 5);
    chk("pause_n", 0, rec_n[0], 192);
    start[0] = 1'b0; tick(3);

    // Interleaved, non-power-of-two geometry
    clr(1); start[1] = 1'b1; t0 = cyc;
    wait_done(1, 200);
    chk("done_latency", 1, done_rise[1] - t0, 33);
    chk("n_valid", 1, rec_n[1], 30);
    chk_el("el0", 1, 0, 0, 0, 0, 0);
    chk_el("el1", 1, 1, 0, 0, 1, 0);
    chk_el("el2", 1, 2, 0, 1, 0, 0);
    chk_el("el29", 1, 29, 4, 2, 1, 1);
    start[1] = 1'b0; tick(3);

    // RD_LAT=1 with start dropped mid-READ
    clr(2); start[2] = 1'b1; t0 = cyc;
    tick(5); start[2] = 1'b0;
    wait_done(2, 200);
    tick(3);
    chk("lag", 2, rec_t[2][0] - first_en[2], 1);
    chk("done_latency", 2, done_rise[2] - t0, 26);
    chk("drain_len", 2, done_rise[2] - (first_en[2] + 23) - 1, 1);
    chk("done_pulse", 2, done_fall[2] - done_rise[2], 1);
    chk("n_valid", 2, rec_n[2], 24);

    // RD_LAT=4
    clr(3); start[3] = 1'b1; t0 = cyc;
    wait_done(3, 200);
    chk("lag", 3, rec_t[3][0] - first_en[3], 4);
    chk("done_latency", 3, done_rise[3] - t0, 23);
    chk("drain_len", 3, done_rise[3] - (first_en[3] + 17) - 1, 4);
    chk("n_valid", 3, rec_n[3], 18);
    chk_el("el17", 3, 17, 1, 2, 2, 1);
    start[3] = 1'b0; tick(3);

    // Asynchronous reset mid-frame, then a fresh frame
    clr(0); start[0] = 1'b1;
    k = 0;
    while (rec_n[0] <= 100 && k < 300) begin tick(1); k++; end
    chk("reached_el100", 0, int'(rec_n[0] > 100), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_busy", 0, int'(busy_v[0]), 0);
    chk("async_rd_en", 0, int'(rd_en_v[0]), 0);
    chk("async_addr", 0, int'(a0), 0);
    chk("async_valid", 0, int'(valid_v[0]), 0);
    chk("async_tags", 0, int'({r0, c0w, h0}), 0);
    chk("async_last", 0, int'(last_v[0]), 0);
    chk("async_done", 0, int'(done_v[0]), 0);
    @(posedge clk); #1 reset = 1'b1; t0 = cyc;
    wait_done(0, 400);
    chk("restart_done", 0, done_rise[0] - t0, 195);
    chk("restart_first_valid", 0, rec_t[0][0] - t0, 3);
    chk("restart_n", 0, rec_n[0], 192);
    chk_el("restart_el0", 0, 0, 0, 0, 0, 0);
    start[0] = 1'b0; tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
